// File: rtl/regbank_write_arbiter_pkg.sv
// Shared encodings for the register-bank write arbiter: FSM states,
// bank source-select codes and requester indices.
package regbank_write_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   localparam logic [1:0] SRC_ALU  = 2'd0;
   localparam logic [1:0] SRC_REG  = 2'd1;
   localparam logic [1:0] SRC_IMM  = 2'd2;
   localparam logic [1:0] SRC_ZERO = 2'd3;

   localparam logic [1:0] IDX_ALU = 2'd0;
   localparam logic [1:0] IDX_MOV = 2'd1;
   localparam logic [1:0] IDX_IMM = 2'd2;
   localparam logic [1:0] IDX_CLR = 2'd3;

   // Each requester owns exactly one bank source.
   function automatic logic [1:0] src_of(logic [1:0] idx);
      case (idx)
         IDX_ALU: return SRC_ALU;
         IDX_MOV: return SRC_REG;
         IDX_IMM: return SRC_IMM;
         default: return SRC_ZERO;
      endcase
   endfunction

endpackage

// File: rtl/regbank_write_arbiter_if.sv
// Requester handshakes plus register-bank control lines of the write arbiter.
// master = requester/bank side, slave = arbiter side.
interface regbank_write_arbiter_if;
   logic       alu_req;
   logic [2:0] alu_dst;
   logic       alu_ack;
   logic       mov_req;
   logic [2:0] mov_dst;
   logic       mov_ack;
   logic       imm_req;
   logic [2:0] imm_dst;
   logic       imm_ack;
   logic       clr_req;
   logic [2:0] clr_dst;
   logic       clr_ack;
   logic       hold;
   logic       MS1;
   logic       MS0;
   logic       RS2;
   logic       RS1;
   logic       RS0;
   logic       E;
   logic       busy;
   logic [1:0] grant;
   logic [7:0] commit_cnt;

   modport master (
      output alu_req, alu_dst, mov_req, mov_dst, imm_req, imm_dst,
             clr_req, clr_dst, hold,
      input  alu_ack, mov_ack, imm_ack, clr_ack,
             MS1, MS0, RS2, RS1, RS0, E, busy, grant, commit_cnt
   );

   modport slave (
      input  alu_req, alu_dst, mov_req, mov_dst, imm_req, imm_dst,
             clr_req, clr_dst, hold,
      output alu_ack, mov_ack, imm_ack, clr_ack,
             MS1, MS0, RS2, RS1, RS0, E, busy, grant, commit_cnt
   );
endinterface

// File: rtl/regbank_write_arbiter_rr_arbiter4.sv
// Combinational 4-way arbiter: round-robin from ptr when rr_en, else lowest index wins.
module rr_arbiter4 (
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   input  logic       rr_en,
   output logic       valid,
   output logic [1:0] winner
);

   logic [1:0] base;
   logic [1:0] idx;

   // Scan from the far end back toward base so the nearest requester is assigned last.
   always_comb begin
      valid  = 1'b0;
      winner = 2'd0;
      idx    = 2'd0;
      base   = rr_en ? ptr : 2'd0;
      for (int k = 3; k >= 0; k--) begin
         idx = base + 2'(k);
         if (req[idx]) begin
            valid  = 1'b1;
            winner = idx;
         end
      end
   end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Write-port controller for the 8x8 register bank: arbitrates four writers and
// sequences MS/RS setup followed by a single-cycle E commit.
//
//   state     | meaning
//   ST_IDLE   | no write owned; arbitrate when hold=0
//   ST_SETUP  | MS/RS driven with E=0, setup down-counter running
//   ST_COMMIT | E=1 and owner ack for exactly one cycle
module regbank_write_arbiter
   import regbank_write_arbiter_pkg::*;
#(
   parameter int SETUP_CYCLES = 1,
   parameter bit RR_ENABLE    = 1'b1
) (
   input logic                   CLK,
   input logic                   RSTn,
   regbank_write_arbiter_if.slave bus
);

   localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYCLES - 1);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [1:0] grant_q, grant_d;
   logic [1:0] ms_q, ms_d;
   logic [2:0] rs_q, rs_d;
   logic       e_q, e_d;
   logic [3:0] ack_q, ack_d;
   logic [1:0] ptr_q, ptr_d;
   logic [7:0] commit_cnt_q, commit_cnt_d;

   logic [3:0] req_vec;
   logic       arb_valid;
   logic [1:0] arb_winner;
   logic [2:0] win_dst;

   assign req_vec = {bus.clr_req, bus.imm_req, bus.mov_req, bus.alu_req};

   rr_arbiter4 u_arb (
      .req    (req_vec),
      .ptr    (ptr_q),
      .rr_en  (RR_ENABLE),
      .valid  (arb_valid),
      .winner (arb_winner)
   );

   always_comb begin
      win_dst = bus.alu_dst;
      case (arb_winner)
         IDX_MOV: win_dst = bus.mov_dst;
         IDX_IMM: win_dst = bus.imm_dst;
         IDX_CLR: win_dst = bus.clr_dst;
         default: ;
      endcase
   end

   // E and ack are registered on entry to COMMIT so they fall on the next edge by default.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      grant_d      = grant_q;
      ms_d         = ms_q;
      rs_d         = rs_q;
      e_d          = 1'b0;
      ack_d        = 4'b0000;
      ptr_d        = ptr_q;
      commit_cnt_d = commit_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (!bus.hold && arb_valid) begin
               state_d = ST_SETUP;
               grant_d = arb_winner;
               ms_d    = src_of(arb_winner);
               rs_d    = win_dst;
               cnt_d   = SETUP_LOAD;
            end
         end
         ST_SETUP: begin
            if (!bus.hold) begin
               if (cnt_q == 4'd0) begin
                  state_d      = ST_COMMIT;
                  e_d          = 1'b1;
                  ack_d        = 4'b0001 << grant_q;
                  commit_cnt_d = commit_cnt_q + 8'd1;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
         ST_COMMIT: begin
            state_d = ST_IDLE;
            ptr_d   = RR_ENABLE ? grant_q + 2'd1 : 2'd0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 4'd0;
         grant_q      <= IDX_ALU;
         ms_q         <= SRC_ALU;
         rs_q         <= 3'd0;
         e_q          <= 1'b0;
         ack_q        <= 4'b0000;
         ptr_q        <= IDX_ALU;
         commit_cnt_q <= 8'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         grant_q      <= grant_d;
         ms_q         <= ms_d;
         rs_q         <= rs_d;
         e_q          <= e_d;
         ack_q        <= ack_d;
         ptr_q        <= ptr_d;
         commit_cnt_q <= commit_cnt_d;
      end
   end

   assign bus.alu_ack    = ack_q[IDX_ALU];
   assign bus.mov_ack    = ack_q[IDX_MOV];
   assign bus.imm_ack    = ack_q[IDX_IMM];
   assign bus.clr_ack    = ack_q[IDX_CLR];
   assign bus.MS1        = ms_q[1];
   assign bus.MS0        = ms_q[0];
   assign bus.RS2        = rs_q[2];
   assign bus.RS1        = rs_q[1];
   assign bus.RS0        = rs_q[0];
   assign bus.E          = e_q;
   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.grant      = grant_q;
   assign bus.commit_cnt = commit_cnt_q;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Bench for regbank_write_arbiter: directed vector table, multi-cycle corner
// sequences, then random traffic against a transaction-level reference model.
module tb_regbank_write_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req_v [2];
   logic [11:0] dst_v [2];
   logic        hold_v [2];
   logic [20:0] out_v [2];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   regbank_write_arbiter_if ifa ();
   regbank_write_arbiter_if ifb ();

   assign ifa.alu_req = req_v[0][0];
   assign ifa.mov_req = req_v[0][1];
   assign ifa.imm_req = req_v[0][2];
   assign ifa.clr_req = req_v[0][3];
   assign ifa.alu_dst = dst_v[0][2:0];
   assign ifa.mov_dst = dst_v[0][5:3];
   assign ifa.imm_dst = dst_v[0][8:6];
   assign ifa.clr_dst = dst_v[0][11:9];
   assign ifa.hold    = hold_v[0];
   assign ifb.alu_req = req_v[1][0];
   assign ifb.mov_req = req_v[1][1];
   assign ifb.imm_req = req_v[1][2];
   assign ifb.clr_req = req_v[1][3];
   assign ifb.alu_dst = dst_v[1][2:0];
   assign ifb.mov_dst = dst_v[1][5:3];
   assign ifb.imm_dst = dst_v[1][8:6];
   assign ifb.clr_dst = dst_v[1][11:9];
   assign ifb.hold    = hold_v[1];

   // Packed view: {E, ack[3:0] (clr,imm,mov,alu), MS[1:0], RS[2:0], busy, grant[1:0], commit_cnt[7:0]}
   assign out_v[0] = {ifa.E, ifa.clr_ack, ifa.imm_ack, ifa.mov_ack, ifa.alu_ack, ifa.MS1, ifa.MS0,
                      ifa.RS2, ifa.RS1, ifa.RS0, ifa.busy, ifa.grant, ifa.commit_cnt};
   assign out_v[1] = {ifb.E, ifb.clr_ack, ifb.imm_ack, ifb.mov_ack, ifb.alu_ack, ifb.MS1, ifb.MS0,
                      ifb.RS2, ifb.RS1, ifb.RS0, ifb.busy, ifb.grant, ifb.commit_cnt};

   regbank_write_arbiter #(.SETUP_CYCLES(1), .RR_ENABLE(1'b1)) dut_a (.CLK(clk), .RSTn(rst_n), .bus(ifa));
   regbank_write_arbiter #(.SETUP_CYCLES(4), .RR_ENABLE(1'b0)) dut_b (.CLK(clk), .RSTn(rst_n), .bus(ifb));

   function automatic logic [20:0] pk(logic e, logic [3:0] ack, logic [1:0] ms, logic [2:0] rs,
                                      logic busy, logic [1:0] g, logic [7:0] c);
      return {e, ack, ms, rs, busy, g, c};
   endfunction

   function automatic logic [11:0] d4(logic [2:0] a, logic [2:0] m, logic [2:0] i, logic [2:0] c);
      return {c, i, m, a};
   endfunction

   // Reference model: owner of the bank write (-1 = none), setup cycles still owed, commit flag.
   typedef struct {
      int owner;
      int left;
      bit commit;
      int ptr;
      int grant;
      int ms;
      int rs;
      int cnt;
   } mdl_t;

   function automatic mdl_t mdl_reset();
      mdl_t m;
      m.owner = -1; m.left = 0; m.commit = 1'b0; m.ptr = 0;
      m.grant = 0; m.ms = 0; m.rs = 0; m.cnt = 0;
      return m;
   endfunction

   function automatic mdl_t mdl_next(mdl_t m, logic [3:0] req, logic [11:0] dsts, logic hold,
                                     int s, bit rr);
      mdl_t n;
      int   start;
      int   i;
      bit   found;
      n = m;
      n.commit = 1'b0;
      if (m.commit) begin
         n.owner = -1;
      end else if (m.owner < 0) begin
         if (!hold && req != 4'b0) begin
            start = rr ? m.ptr : 0;
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
               i = (start + k) % 4;
               if (!found && req[i]) begin
                  found = 1'b1;
                  n.owner = i;
               end
            end
            n.grant = n.owner;
            n.ms = n.owner;
            n.rs = int'(dsts[n.owner*3 +: 3]);
            n.left = s;
         end
      end else if (!hold) begin
         n.left = m.left - 1;
         if (n.left == 0) begin
            n.commit = 1'b1;
            n.cnt = (m.cnt + 1) % 256;
            n.ptr = rr ? (m.owner + 1) % 4 : 0;
         end
      end
      return n;
   endfunction

   function automatic logic [20:0] mdl_exp(mdl_t m);
      return pk(m.commit, m.commit ? 4'(1 << m.owner) : 4'd0, 2'(m.ms), 3'(m.rs),
                m.owner >= 0, 2'(m.grant), 8'(m.cnt));
   endfunction

   mdl_t mdl [2];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mdl[0] <= mdl_reset();
         mdl[1] <= mdl_reset();
      end else begin
         mdl[0] <= mdl_next(mdl[0], req_v[0], dst_v[0], hold_v[0], 1, 1'b1);
         mdl[1] <= mdl_next(mdl[1], req_v[1], dst_v[1], hold_v[1], 4, 1'b0);
      end
   end

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req_v[0] = 4'b0; req_v[1] = 4'b0;
      hold_v[0] = 1'b0; hold_v[1] = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic int ack_idx(logic [3:0] a);
      int r;
      r = -1;
      for (int j = 0; j < 4; j++) if (a[j]) r = j;
      return r;
   endfunction

   typedef struct {
      logic [3:0]  req;
      logic [11:0] dst;
      logic        hold;
      logic [20:0] exp;
   } vec_t;

   vec_t tbl [17];

   initial begin
      int n, last, idx, cnt, pulses, bad, first_cnt, final_cnt;
      logic e_seen, found;
      logic [11:0] dd, de;

      req_v[0] = 4'b0; req_v[1] = 4'b0;
      dst_v[0] = 12'b0; dst_v[1] = 12'b0;
      hold_v[0] = 1'b0; hold_v[1] = 1'b0;

      dd = d4(3'd5, 3'd2, 3'd6, 3'd7);
      de = d4(3'd3, 3'd2, 3'd6, 3'd7);
      tbl[0]  = '{4'b0001, dd, 1'b0, pk(1'b0, 4'b0000, 2'd0, 3'd5, 1'b1, 2'd0, 8'd0)};
      tbl[1]  = '{4'b0001, dd, 1'b0, pk(1'b1, 4'b0001, 2'd0, 3'd5, 1'b1, 2'd0, 8'd1)};
      tbl[2]  = '{4'b0000, dd, 1'b0, pk(1'b0, 4'b0000, 2'd0, 3'd5, 1'b0, 2'd0, 8'd1)};
      tbl[3]  = '{4'b1010, dd, 1'b0, pk(1'b0, 4'b0000, 2'd1, 3'd2, 1'b1, 2'd1, 8'd1)};
      tbl[4]  = '{4'b1010, dd, 1'b1, pk(1'b0, 4'b0000, 2'd1, 3'd2, 1'b1, 2'd1, 8'd1)};
      tbl[5]  = '{4'b1010, dd, 1'b0, pk(1'b1, 4'b0010, 2'd1, 3'd2, 1'b1, 2'd1, 8'd2)};
      tbl[6]  = '{4'b1000, dd, 1'b0, pk(1'b0, 4'b0000, 2'd1, 3'd2, 1'b0, 2'd1, 8'd2)};
      tbl[7]  = '{4'b1001, de, 1'b0, pk(1'b0, 4'b0000, 2'd3, 3'd7, 1'b1, 2'd3, 8'd2)};
      tbl[8]  = '{4'b1001, de, 1'b0, pk(1'b1, 4'b1000, 2'd3, 3'd7, 1'b1, 2'd3, 8'd3)};
      tbl[9]  = '{4'b0001, de, 1'b0, pk(1'b0, 4'b0000, 2'd3, 3'd7, 1'b0, 2'd3, 8'd3)};
      tbl[10] = '{4'b0001, de, 1'b0, pk(1'b0, 4'b0000, 2'd0, 3'd3, 1'b1, 2'd0, 8'd3)};
      tbl[11] = '{4'b0000, de, 1'b0, pk(1'b1, 4'b0001, 2'd0, 3'd3, 1'b1, 2'd0, 8'd4)};
      tbl[12] = '{4'b0000, de, 1'b0, pk(1'b0, 4'b0000, 2'd0, 3'd3, 1'b0, 2'd0, 8'd4)};
      tbl[13] = '{4'b0100, de, 1'b1, pk(1'b0, 4'b0000, 2'd0, 3'd3, 1'b0, 2'd0, 8'd4)};
      tbl[14] = '{4'b0100, de, 1'b0, pk(1'b0, 4'b0000, 2'd2, 3'd6, 1'b1, 2'd2, 8'd4)};
      tbl[15] = '{4'b0000, de, 1'b0, pk(1'b1, 4'b0100, 2'd2, 3'd6, 1'b1, 2'd2, 8'd5)};
      tbl[16] = '{4'b0000, de, 1'b0, pk(1'b0, 4'b0000, 2'd2, 3'd6, 1'b0, 2'd2, 8'd5)};

      // Reset state
      repeat (2) @(negedge clk);
      check("reset_a", 32'(out_v[0]), 32'h0);
      check("reset_b", 32'(out_v[1]), 32'h0);
      rst_n = 1'b1;

      // Directed vectors on dut_a (SETUP_CYCLES=1, round-robin)
      for (int r = 0; r < 17; r++) begin
         req_v[0] = tbl[r].req;
         dst_v[0] = tbl[r].dst;
         hold_v[0] = tbl[r].hold;
         @(negedge clk);
         check($sformatf("vec%0d", r), 32'(out_v[0]), 32'(tbl[r].exp));
      end

      // All four held with round-robin: 0,1,2,3,0 spaced 3 cycles
      do_reset();
      req_v[0] = 4'hF;
      dst_v[0] = d4(3'd1, 3'd2, 3'd3, 3'd4);
      n = 0; last = 0;
      for (int c = 0; c < 40 && n < 5; c++) begin
         @(negedge clk);
         if (out_v[0][19:16] != 4'b0) begin
            idx = ack_idx(out_v[0][19:16]);
            check($sformatf("rr_onehot%0d", n), 32'($countones(out_v[0][19:16])), 32'd1);
            check($sformatf("rr_order%0d", n), 32'(idx), 32'(n % 4));
            check($sformatf("rr_ms%0d", n), 32'(out_v[0][15:14]), 32'(idx));
            if (n > 0) check($sformatf("rr_spacing%0d", n), 32'(c - last), 32'd3);
            last = c;
            n++;
         end
      end
      check("rr_ack_count", 32'(n), 32'd5);

      // Fixed priority (dut_b, SETUP_CYCLES=4): ALU repeats, MOV starved until ALU drops
      do_reset();
      req_v[1] = 4'hF;
      dst_v[1] = d4(3'd1, 3'd2, 3'd3, 3'd4);
      n = 0; last = 0;
      for (int c = 0; c < 60 && n < 3; c++) begin
         @(negedge clk);
         if (out_v[1][19:16] != 4'b0) begin
            check($sformatf("fp_alu%0d", n), 32'(out_v[1][19:16]), 32'b0001);
            if (n > 0) check($sformatf("fp_spacing%0d", n), 32'(c - last), 32'd6);
            last = c;
            n++;
         end
      end
      check("fp_ack_count", 32'(n), 32'd3);
      req_v[1][0] = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         if (out_v[1][19:16] != 4'b0) begin
            found = 1'b1;
            check("fp_mov_after_alu", 32'(out_v[1][19:16]), 32'b0010);
         end
      end
      check("fp_mov_seen", 32'(found), 32'd1);

      // hold during SETUP (dut_b, SETUP_CYCLES=4)
      do_reset();
      req_v[1] = 4'b0100;
      dst_v[1] = d4(3'd0, 3'd0, 3'd1, 3'd0);
      @(negedge clk);
      check("hold_busy", 32'(out_v[1][10]), 32'd1);
      @(negedge clk);
      hold_v[1] = 1'b1;
      e_seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         e_seen = e_seen | out_v[1][20];
      end
      check("hold_e_low", 32'(e_seen), 32'd0);
      hold_v[1] = 1'b0;
      cnt = 0;
      found = 1'b0;
      for (int c = 0; c < 12 && !found; c++) begin
         @(negedge clk);
         cnt++;
         if (out_v[1][20]) found = 1'b1;
      end
      check("hold_release_latency", 32'(cnt), 32'd3);
      check("hold_commit_sel", 32'(out_v[1][15:11]), 32'({2'd2, 3'd1}));
      check("hold_commit_ack", 32'(out_v[1][19:16]), 32'b0100);
      req_v[1] = 4'b0;

      // Reset pulsed during COMMIT on dut_a
      do_reset();
      req_v[0] = 4'b0001;
      dst_v[0] = d4(3'd5, 3'd0, 3'd0, 3'd0);
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         @(negedge clk);
         if (out_v[0][20]) found = 1'b1;
      end
      check("rst_commit_reached", 32'(found), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_abort_outputs", 32'(out_v[0]), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         @(negedge clk);
         if (out_v[0][20]) found = 1'b1;
      end
      check("rst_retry_ack", 32'(out_v[0][19:16]), 32'b0001);
      check("rst_retry_cnt", 32'(out_v[0][7:0]), 32'd1);
      check("rst_retry_rs", 32'(out_v[0][13:11]), 32'd5);
      req_v[0] = 4'b0;

      // 256 clears to r7: commit_cnt wraps to 0
      do_reset();
      req_v[0] = 4'b1000;
      dst_v[0] = d4(3'd0, 3'd0, 3'd0, 3'd7);
      pulses = 0; bad = 0; first_cnt = -1; final_cnt = -1;
      for (int c = 0; c < 900 && pulses < 256; c++) begin
         @(negedge clk);
         if (out_v[0][20]) begin
            pulses++;
            if (out_v[0][15:11] != {2'd3, 3'd7} || out_v[0][19:16] != 4'b1000) bad++;
            if (pulses == 1) first_cnt = int'(out_v[0][7:0]);
            if (pulses == 256) final_cnt = int'(out_v[0][7:0]);
         end
      end
      check("clr_pulses", 32'(pulses), 32'd256);
      check("clr_bad_sel", 32'(bad), 32'd0);
      check("clr_first_cnt", 32'(first_cnt), 32'd1);
      check("clr_wrap_cnt", 32'(final_cnt), 32'd0);

      // Random traffic on both DUTs against the reference model
      do_reset();
      for (int cyc = 0; cyc < 1500; cyc++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            check($sformatf("model_dut%0d_cyc%0d", d, cyc), 32'(out_v[d]), 32'(mdl_exp(mdl[d])));
            for (int i = 0; i < 4; i++) begin
               if (req_v[d][i]) begin
                  if (out_v[d][16+i] && $urandom_range(3) != 0) req_v[d][i] = 1'b0;
               end else if ($urandom_range(2) == 0) begin
                  req_v[d][i] = 1'b1;
                  dst_v[d][3*i +: 3] = 3'($urandom_range(7));
               end
            end
            hold_v[d] = ($urandom_range(4) == 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
